// File: rtl/kpn_adder_process_if.sv
// Token-queue bundle for the KPN adder: two input queues, one output queue, status.
// master = process node side, slave = queue/environment side.
interface kpn_adder_process_if #(
   parameter int BITS_NUMBER = 16,
   parameter int COUNT_W     = 8
);
   logic [BITS_NUMBER-1:0] a_data;
   logic                   a_empty;
   logic                   a_rd;
   logic [BITS_NUMBER-1:0] b_data;
   logic                   b_empty;
   logic                   b_rd;
   logic [BITS_NUMBER-1:0] out_data;
   logic                   out_full;
   logic                   out_wr;
   logic                   overflow;
   logic [COUNT_W-1:0]     token_count;
   logic                   busy;

   modport master (
      input  a_data, a_empty, b_data, b_empty, out_full,
      output a_rd, b_rd, out_data, out_wr, overflow, token_count, busy
   );

   modport slave (
      output a_data, a_empty, b_data, b_empty, out_full,
      input  a_rd, b_rd, out_data, out_wr, overflow, token_count, busy
   );
endinterface

// File: rtl/kpn_adder_process.sv
// KPN adder process: blocking read of A, then B, blocking write of A+B downstream.
// Queue data arrives the cycle after the read strobe, hence the CAP_x states.
module kpn_adder_process #(
   parameter int BITS_NUMBER = 16,
   parameter int SATURATE    = 0,
   parameter int COUNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   kpn_adder_process_if.master  bus
);

   typedef enum logic [2:0] {
      IDLE,
      RD_A,
      CAP_A,
      RD_B,
      CAP_B,
      WR
   } state_t;

   state_t                 state_q, state_d;
   logic [BITS_NUMBER-1:0] reg_a_q, reg_a_d;
   logic [BITS_NUMBER-1:0] out_data_q, out_data_d;
   logic                   overflow_q, overflow_d;
   logic [COUNT_W-1:0]     count_q, count_d;

   logic [BITS_NUMBER:0]   full;
   logic [BITS_NUMBER-1:0] sum;

   always_comb begin
      full = {1'b0, reg_a_q} + {1'b0, bus.b_data};
      sum  = ((SATURATE != 0) && full[BITS_NUMBER]) ? '1 : full[BITS_NUMBER-1:0];

      state_d    = state_q;
      reg_a_d    = reg_a_q;
      out_data_d = out_data_q;
      overflow_d = overflow_q;
      count_d    = count_q;

      case (state_q)
         IDLE:  state_d = RD_A;
         RD_A:  if (!bus.a_empty) state_d = CAP_A;
         CAP_A: begin
            reg_a_d = bus.a_data;
            state_d = RD_B;
         end
         RD_B:  if (!bus.b_empty) state_d = CAP_B;
         CAP_B: begin
            out_data_d = sum;
            if (full[BITS_NUMBER]) overflow_d = 1'b1;
            state_d = WR;
         end
         WR: begin
            if (!bus.out_full) begin
               count_d = count_q + COUNT_W'(1);
               state_d = RD_A;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         reg_a_q    <= '0;
         out_data_q <= '0;
         overflow_q <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         reg_a_q    <= reg_a_d;
         out_data_q <= out_data_d;
         overflow_q <= overflow_d;
         count_q    <= count_d;
      end
   end

   // Strobes decode straight from state so a queue turning non-empty is served that cycle.
   assign bus.a_rd        = (state_q == RD_A) && !bus.a_empty;
   assign bus.b_rd        = (state_q == RD_B) && !bus.b_empty;
   assign bus.out_wr      = (state_q == WR)   && !bus.out_full;
   assign bus.out_data    = out_data_q;
   assign bus.overflow    = overflow_q;
   assign bus.token_count = count_q;
   assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_kpn_adder_process.sv
// Bench for kpn_adder_process: a wrapping/8-bit-count DUT and a saturating/2-bit-count DUT
// share one set of modelled input/output queues; a scoreboard checks every written token.
module tb_kpn_adder_process;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   kpn_adder_process_if #(.BITS_NUMBER(16), .COUNT_W(8)) ifa ();
   kpn_adder_process_if #(.BITS_NUMBER(16), .COUNT_W(2)) ifb ();

   assign ifb.a_data   = ifa.a_data;
   assign ifb.a_empty  = ifa.a_empty;
   assign ifb.b_data   = ifa.b_data;
   assign ifb.b_empty  = ifa.b_empty;
   assign ifb.out_full = ifa.out_full;

   kpn_adder_process #(.BITS_NUMBER(16), .SATURATE(0), .COUNT_W(8)) dut_wrap (
      .clk(clk), .reset_n(reset_n), .bus(ifa.master)
   );
   kpn_adder_process #(.BITS_NUMBER(16), .SATURATE(1), .COUNT_W(2)) dut_sat (
      .clk(clk), .reset_n(reset_n), .bus(ifb.master)
   );

   typedef struct {
      logic [15:0] wrap;
      logic [15:0] sat;
      logic        ovf;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] a_q[$];
   logic [15:0] b_q[$];
   int          compared = 0;
   int          mismatched = 0;
   bit          ovf_model = 1'b0;
   int unsigned cnt_model = 0;
   int          a_pops = 0;
   int          b_pops = 0;
   bit          rnd_done = 1'b0;

   function automatic void check(string name, longint unsigned act, longint unsigned exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void push_exp(logic [15:0] a, logic [15:0] b);
      int unsigned s;
      exp_t e;
      s = int'(a) + int'(b);
      e.wrap = 16'(s % 65536);
      e.sat  = (s > 65535) ? 16'hFFFF : 16'(s);
      if (s > 65535) ovf_model = 1'b1;
      e.ovf = ovf_model;
      sb.push_back(e);
   endfunction

   task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
      a_q.push_back(a);
      b_q.push_back(b);
      push_exp(a, b);
   endtask

   task automatic wait_drain(input int max_cycles);
      int n;
      n = 0;
      while (sb.size() != 0 && n < max_cycles) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (sb.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain_timeout: %0d tokens still pending, expected 0", sb.size());
      end
   endtask

   // Input queue model: data and empty flags update just after the edge that saw the strobe.
   initial begin
      bit ra, rb;
      ifa.a_data   = '0;
      ifa.b_data   = '0;
      ifa.a_empty  = 1'b1;
      ifa.b_empty  = 1'b1;
      ifa.out_full = 1'b0;
      forever begin
         @(negedge clk);
         ra = ifa.a_rd;
         rb = ifa.b_rd;
         @(posedge clk);
         #1;
         if (ra) begin
            check("a_rd_nonempty", longint'(a_q.size() > 0), 1);
            if (a_q.size() > 0) begin
               ifa.a_data = a_q.pop_front();
               a_pops++;
            end
         end
         if (rb) begin
            check("ab_order", a_pops, b_pops + 1);
            check("b_rd_nonempty", longint'(b_q.size() > 0), 1);
            if (b_q.size() > 0) begin
               ifa.b_data = b_q.pop_front();
               b_pops++;
            end
         end
         ifa.a_empty = (a_q.size() == 0);
         ifa.b_empty = (b_q.size() == 0);
      end
   end

   // Output monitor: every accepted write is matched against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n && ifa.out_wr) begin
         check("wr_while_full", ifa.out_full, 0);
         check("sat_dut_wr_in_step", ifb.out_wr, 1);
         if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_write: got 0x%0h, expected no write", ifa.out_data);
         end else begin
            e = sb.pop_front();
            check("sum_wrap",     ifa.out_data, e.wrap);
            check("sum_sat",      ifb.out_data, e.sat);
            check("ovf_wrap",     ifa.overflow, e.ovf);
            check("ovf_sat",      ifb.overflow, e.ovf);
            check("count_w8",     ifa.token_count, cnt_model % 256);
            check("count_w2",     ifb.token_count, cnt_model % 4);
            cnt_model++;
         end
      end
   end

   initial begin
      int lat;
      bit found;
      int bp;
      logic [15:0] ra, rb;

      // Reset state, preload two pairs, measure first-write latency.
      push_pair(16'h0001, 16'h0002);
      push_pair(16'h0010, 16'h0020);
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {ifa.a_rd, ifa.b_rd, ifa.out_wr, ifa.out_data, ifa.overflow, ifa.token_count, ifa.busy}, 0);
      reset_n = 1'b1;
      lat = 0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         lat++;
         if (ifa.out_wr) found = 1'b1;
      end
      check("first_wr_latency", lat, 5);
      wait_drain(100);
      @(negedge clk);
      check("a_rd_pulses", a_pops, 2);
      check("b_rd_pulses", b_pops, 2);
      check("count_after_two", ifa.token_count, 2);

      // Carry-out: wraps to 0x0001, saturates to 0xFFFF, overflow sticky.
      push_pair(16'hFFFF, 16'h0002);
      wait_drain(100);
      @(negedge clk);
      check("ovf_sticky", ifa.overflow, 1);

      // A empty, B ready: B must not be read until A's token arrives.
      b_q.push_back(16'h0005);
      bp = b_pops;
      repeat (10) @(negedge clk);
      check("no_b_rd_while_a_empty", b_pops, bp);
      a_q.push_back(16'h0007);
      push_exp(16'h0007, 16'h0005);
      wait_drain(100);

      // Output full stall in WR.
      @(negedge clk);
      ifa.out_full = 1'b1;
      push_pair(16'h1200, 16'h0034);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (ifa.out_data == 16'h1234) found = 1'b1;
      end
      check("reach_wr_stall", found, 1);
      repeat (6) begin
         check("stall_no_wr",     ifa.out_wr, 0);
         check("stall_data_hold", ifa.out_data, 16'h1234);
         check("stall_count",     ifa.token_count, cnt_model % 256);
         @(negedge clk);
      end
      @(posedge clk);
      #2 ifa.out_full = 1'b0;
      #1 check("wr_on_release", ifa.out_wr, 1);
      wait_drain(100);

      // Asynchronous reset while in CAP_B; the in-flight pair is lost.
      a_q.push_back(16'hFFFF);
      b_q.push_back(16'h0002);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (ifa.b_rd) found = 1'b1;
      end
      check("saw_b_rd", found, 1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("async_reset_wrap",
            {ifa.a_rd, ifa.b_rd, ifa.out_wr, ifa.out_data, ifa.overflow, ifa.token_count, ifa.busy}, 0);
      check("async_reset_sat",
            {ifb.a_rd, ifb.b_rd, ifb.out_wr, ifb.out_data, ifb.overflow, ifb.token_count, ifb.busy}, 0);
      sb.delete();
      ovf_model = 1'b0;
      cnt_model = 0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1 check("idle_after_release", ifa.busy, 0);
      @(negedge clk);
      check("rd_a_after_idle", ifa.busy, 1);
      push_pair(16'h0100, 16'h0023);
      wait_drain(100);

      // Randomized pairs with random gaps and random back-pressure.
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 6)) @(negedge clk);
               ra = 16'($urandom);
               rb = 16'($urandom);
               if ($urandom_range(0, 3) == 0) ra = ra | 16'hF000;
               if ($urandom_range(0, 3) == 0) rb = rb | 16'hF000;
               push_pair(ra, rb);
            end
            wait_drain(3000);
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #2 ifa.out_full = ($urandom_range(0, 3) == 0);
            end
            ifa.out_full = 1'b0;
         end
      join

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
      $fatal(1, "watchdog");
   end

endmodule
